// File: rtl/snake_body_engine.sv
// Snake body engine: segment shift register, RUN/CHECK move FSM, growth and death control.
// Optional macro SNAKE_WRAP_EN: a head leaving the field re-enters on the opposite edge.
module snake_body_engine #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned STEP    = 10,
    parameter int unsigned FIELD_W = 640,
    parameter int unsigned FIELD_H = 480,
    parameter int unsigned START_X = 320,
    parameter int unsigned START_Y = 240
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    input  logic                  in_tick,
    input  logic [1:0]            in_dir,
    input  logic                  in_dir_valid,
    input  logic                  in_lethal,
    input  logic                  in_apple,
    output logic [MAX_LEN*10-1:0] out_snakeX,
    output logic [MAX_LEN*9-1:0]  out_snakeY,
    output logic [7:0]            out_snake_size,
    output logic [9:0]            out_headX,
    output logic [8:0]            out_headY,
    output logic                  out_ate,
    output logic                  out_running,
    output logic                  out_dead
);

    localparam int unsigned XW   = 10;
    localparam int unsigned YW   = 9;
    localparam int unsigned SW   = 8;
    localparam int unsigned XTOT = MAX_LEN * XW;
    localparam int unsigned YTOT = MAX_LEN * YW;

    localparam logic [XTOT-1:0]      RST_X  = XTOT'(START_X);
    localparam logic [YTOT-1:0]      RST_Y  = YTOT'(START_Y);
    localparam logic [SW-1:0]        LEN_MAX = SW'(MAX_LEN);
    localparam logic signed [XW:0]   X_MAX  = (XW+1)'(FIELD_W - STEP);
    localparam logic signed [YW:0]   Y_MAX  = (YW+1)'(FIELD_H - STEP);
    localparam logic signed [XW:0]   STEP_X = (XW+1)'(STEP);
    localparam logic signed [YW:0]   STEP_Y = (YW+1)'(STEP);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t           r_state;
    logic [XTOT-1:0]  r_snake_x;
    logic [YTOT-1:0]  r_snake_y;
    logic [SW-1:0]    r_size;
    logic [1:0]       r_dir;
    logic             r_grow_pend;
    logic             r_tick_pend;
    logic             r_ate;

    logic signed [XW:0] w_hx;
    logic signed [YW:0] w_hy;
    logic signed [XW:0] w_nx;
    logic signed [YW:0] w_ny;
    logic               w_oob;
    logic               w_die_oob;
    logic [XW-1:0]      w_new_x;
    logic [YW-1:0]      w_new_y;
    logic               w_rev;
    logic               w_dir_ok;
    logic               w_move;

    // Candidate head one step ahead, one bit wider so underflow shows as a negative value.
    always_comb begin
        w_hx = {1'b0, r_snake_x[XW-1:0]};
        w_hy = {1'b0, r_snake_y[YW-1:0]};
        w_nx = w_hx;
        w_ny = w_hy;
        case (r_dir)
            DIR_UP:    w_ny = w_hy - STEP_Y;
            DIR_RIGHT: w_nx = w_hx + STEP_X;
            DIR_DOWN:  w_ny = w_hy + STEP_Y;
            default:   w_nx = w_hx - STEP_X;
        endcase
        w_oob = w_nx[XW] || (w_nx > X_MAX) || w_ny[YW] || (w_ny > Y_MAX);
    end

`ifdef SNAKE_WRAP_EN
    // Re-enter on the opposite edge; the move always completes.
    always_comb begin
        w_die_oob = 1'b0;
        if (w_nx[XW])
            w_new_x = X_MAX[XW-1:0];
        else if (w_nx > X_MAX)
            w_new_x = '0;
        else
            w_new_x = w_nx[XW-1:0];
        if (w_ny[YW])
            w_new_y = Y_MAX[YW-1:0];
        else if (w_ny > Y_MAX)
            w_new_y = '0;
        else
            w_new_y = w_ny[YW-1:0];
    end
`else
    // Leaving the field is fatal; the move is abandoned.
    always_comb begin
        w_die_oob = w_oob;
        w_new_x   = w_nx[XW-1:0];
        w_new_y   = w_ny[YW-1:0];
    end
`endif

    // Opposite directions differ by exactly 2 in this encoding.
    assign w_rev    = ((in_dir ^ r_dir) == 2'd2);
    assign w_dir_ok = in_dir_valid && (!w_rev || (r_size == 8'd1));
    assign w_move   = in_tick || r_tick_pend;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state     <= S_IDLE;
            r_snake_x   <= RST_X;
            r_snake_y   <= RST_Y;
            r_size      <= 8'd1;
            r_dir       <= DIR_RIGHT;
            r_grow_pend <= 1'b0;
            r_tick_pend <= 1'b0;
            r_ate       <= 1'b0;
        end else begin
            r_ate <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_start)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_dir_ok)
                        r_dir <= in_dir;
                    if (w_move) begin
                        r_tick_pend <= 1'b0;
                        if (w_die_oob) begin
                            r_state <= S_DEAD;
                        end else begin
                            r_snake_x <= {r_snake_x[XTOT-XW-1:0], w_new_x};
                            r_snake_y <= {r_snake_y[YTOT-YW-1:0], w_new_y};
                            if (r_grow_pend) begin
                                if (r_size < LEN_MAX)
                                    r_size <= r_size + 8'd1;
                                r_grow_pend <= 1'b0;
                            end
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_dir_ok)
                        r_dir <= in_dir;
                    if (in_tick)
                        r_tick_pend <= 1'b1;
                    if (in_lethal) begin
                        r_state <= S_DEAD;
                    end else begin
                        if (in_apple) begin
                            r_ate       <= 1'b1;
                            r_grow_pend <= 1'b1;
                        end
                        r_state <= S_RUN;
                    end
                end
                S_DEAD: begin
                    // Restart reloads everything but lands directly in RUN.
                    if (in_start) begin
                        r_state     <= S_RUN;
                        r_snake_x   <= RST_X;
                        r_snake_y   <= RST_Y;
                        r_size      <= 8'd1;
                        r_dir       <= DIR_RIGHT;
                        r_grow_pend <= 1'b0;
                        r_tick_pend <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_snakeX     = r_snake_x;
    assign out_snakeY     = r_snake_y;
    assign out_snake_size = r_size;
    assign out_headX      = r_snake_x[XW-1:0];
    assign out_headY      = r_snake_y[YW-1:0];
    assign out_ate        = r_ate;
    assign out_running    = (r_state == S_RUN) || (r_state == S_CHECK);
    assign out_dead       = (r_state == S_DEAD);

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: vector table plus hand sequences for boundaries,
// saturation and asynchronous reset, with expectations queued on a scoreboard.
module tb_snake_body_engine;

    localparam int unsigned MAX_LEN = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  tick;
    logic [1:0]            dir;
    logic                  dir_valid;
    logic                  lethal;
    logic                  apple;
    logic [MAX_LEN*10-1:0] snake_x;
    logic [MAX_LEN*9-1:0]  snake_y;
    logic [7:0]            size;
    logic [9:0]            head_x;
    logic [8:0]            head_y;
    logic                  ate;
    logic                  running;
    logic                  dead;

    snake_body_engine dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_start       (start),
        .in_tick        (tick),
        .in_dir         (dir),
        .in_dir_valid   (dir_valid),
        .in_lethal      (lethal),
        .in_apple       (apple),
        .out_snakeX     (snake_x),
        .out_snakeY     (snake_y),
        .out_snake_size (size),
        .out_headX      (head_x),
        .out_headY      (head_y),
        .out_ate        (ate),
        .out_running    (running),
        .out_dead       (dead)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       tick;
        logic [1:0] dir;
        logic       dv;
        logic       lethal;
        logic       apple;
    } in_t;

    typedef struct packed {
        logic [9:0] hx;
        logic [8:0] hy;
        logic [9:0] s1x;
        logic [8:0] s1y;
        logic [7:0] size;
        logic       run;
        logic       dead;
        logic       ate;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vt[25];

    function automatic in_t mk_in(input bit st, input bit tk, input int d, input bit dv,
                                  input bit le, input bit ap);
        in_t r;
        r.start  = st;
        r.tick   = tk;
        r.dir    = 2'(d);
        r.dv     = dv;
        r.lethal = le;
        r.apple  = ap;
        return r;
    endfunction

    function automatic exp_t mk_exp(input int hx, input int hy, input int s1x, input int s1y,
                                    input int sz, input bit rn, input bit dd, input bit at);
        exp_t r;
        r.hx   = 10'(hx);
        r.hy   = 9'(hy);
        r.s1x  = 10'(s1x);
        r.s1y  = 9'(s1y);
        r.size = 8'(sz);
        r.run  = rn;
        r.dead = dd;
        r.ate  = at;
        return r;
    endfunction

    task automatic run_cycle(input in_t i);
        start     = i.start;
        tick      = i.tick;
        dir       = i.dir;
        dir_valid = i.dv;
        lethal    = i.lethal;
        apple     = i.apple;
        @(posedge clk);
        #1;
        start     = 1'b0;
        tick      = 1'b0;
        dir_valid = 1'b0;
        lethal    = 1'b0;
        apple     = 1'b0;
    endtask

    task automatic check_pop(input string name);
        exp_t a;
        exp_t e;
        a.hx   = head_x;
        a.hy   = head_y;
        a.s1x  = snake_x[19:10];
        a.s1y  = snake_y[17:9];
        a.size = size;
        a.run  = running;
        a.dead = dead;
        a.ate  = ate;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got head=(%0d,%0d) seg1=(%0d,%0d) size=%0d run=%0b dead=%0b ate=%0b, expected head=(%0d,%0d) seg1=(%0d,%0d) size=%0d run=%0b dead=%0b ate=%0b",
                         name, a.hx, a.hy, a.s1x, a.s1y, a.size, a.run, a.dead, a.ate,
                         e.hx, e.hy, e.s1x, e.s1y, e.size, e.run, e.dead, e.ate);
            end
        end
    endtask

    task automatic apply(input string name, input in_t i, input exp_t e);
        sb.push_back(e);
        run_cycle(i);
        check_pop(name);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_t nop;
        in_t tk;
        nop = mk_in(0, 0, 0, 0, 0, 0);
        tk  = mk_in(0, 1, 0, 0, 0, 0);

        //                  st tk d dv le ap            hx   hy   s1x  s1y sz rn dd at
        vt[0]  = '{mk_in(0, 0, 0, 0, 0, 0), mk_exp(320, 240,   0,   0, 1, 0, 0, 0)};
        vt[1]  = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(320, 240,   0,   0, 1, 0, 0, 0)};
        vt[2]  = '{mk_in(1, 0, 0, 0, 0, 0), mk_exp(320, 240,   0,   0, 1, 1, 0, 0)};
        vt[3]  = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(330, 240, 320, 240, 1, 1, 0, 0)};
        vt[4]  = '{mk_in(0, 0, 0, 0, 0, 0), mk_exp(330, 240, 320, 240, 1, 1, 0, 0)};
        vt[5]  = '{mk_in(0, 0, 0, 0, 0, 1), mk_exp(330, 240, 320, 240, 1, 1, 0, 0)};
        vt[6]  = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(340, 240, 330, 240, 1, 1, 0, 0)};
        vt[7]  = '{mk_in(0, 0, 0, 0, 0, 1), mk_exp(340, 240, 330, 240, 1, 1, 0, 1)};
        vt[8]  = '{mk_in(0, 0, 0, 0, 0, 0), mk_exp(340, 240, 330, 240, 1, 1, 0, 0)};
        vt[9]  = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(350, 240, 340, 240, 2, 1, 0, 0)};
        vt[10] = '{mk_in(0, 0, 3, 1, 0, 0), mk_exp(350, 240, 340, 240, 2, 1, 0, 0)};
        vt[11] = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(360, 240, 350, 240, 2, 1, 0, 0)};
        vt[12] = '{mk_in(0, 0, 0, 1, 0, 0), mk_exp(360, 240, 350, 240, 2, 1, 0, 0)};
        vt[13] = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(360, 230, 360, 240, 2, 1, 0, 0)};
        vt[14] = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(360, 230, 360, 240, 2, 1, 0, 0)};
        vt[15] = '{mk_in(0, 0, 0, 0, 0, 0), mk_exp(360, 220, 360, 230, 2, 1, 0, 0)};
        vt[16] = '{mk_in(0, 0, 0, 0, 1, 1), mk_exp(360, 220, 360, 230, 2, 0, 1, 0)};
        vt[17] = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(360, 220, 360, 230, 2, 0, 1, 0)};
        vt[18] = '{mk_in(0, 1, 2, 1, 0, 0), mk_exp(360, 220, 360, 230, 2, 0, 1, 0)};
        vt[19] = '{mk_in(1, 0, 0, 0, 0, 0), mk_exp(320, 240,   0,   0, 1, 1, 0, 0)};
        vt[20] = '{mk_in(0, 0, 3, 1, 0, 0), mk_exp(320, 240,   0,   0, 1, 1, 0, 0)};
        vt[21] = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(310, 240, 320, 240, 1, 1, 0, 0)};
        vt[22] = '{mk_in(0, 0, 1, 1, 0, 0), mk_exp(310, 240, 320, 240, 1, 1, 0, 0)};
        vt[23] = '{mk_in(0, 1, 0, 0, 0, 0), mk_exp(320, 240, 310, 240, 1, 1, 0, 0)};
        vt[24] = '{mk_in(0, 0, 0, 0, 0, 0), mk_exp(320, 240, 310, 240, 1, 1, 0, 0)};

        rst = 1'b1;
        start = 1'b0; tick = 1'b0; dir = 2'd0; dir_valid = 1'b0; lethal = 1'b0; apple = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk_exp(320, 240, 0, 0, 1, 0, 0, 0));
        check_pop("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 25; i++)
            apply($sformatf("vec%0d", i), vt[i].i, vt[i].e);

        // Walk right to the last legal column, then step past it.
        for (int k = 0; k < 31; k++) begin
            run_cycle(tk);
            run_cycle(nop);
        end
        apply("right_edge", nop, mk_exp(630, 240, 620, 240, 1, 1, 0, 0));
`ifdef SNAKE_WRAP_EN
        apply("right_oob", tk, mk_exp(0, 240, 630, 240, 1, 1, 0, 0));
`else
        apply("right_oob", tk, mk_exp(630, 240, 620, 240, 1, 0, 1, 0));
`endif

        // Walk up to row 0, then step past it (underflow).
        pulse_reset();
        run_cycle(mk_in(1, 0, 0, 0, 0, 0));
        run_cycle(mk_in(0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 24; k++) begin
            run_cycle(tk);
            run_cycle(nop);
        end
        apply("top_edge", nop, mk_exp(320, 0, 320, 10, 1, 1, 0, 0));
`ifdef SNAKE_WRAP_EN
        apply("top_oob", tk, mk_exp(320, 470, 320, 0, 1, 1, 0, 0));
`else
        apply("top_oob", tk, mk_exp(320, 0, 320, 10, 1, 0, 1, 0));
`endif

        // Grow with an apple on every check until the length saturates.
        pulse_reset();
        run_cycle(mk_in(1, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 17; k++) begin
            apply($sformatf("grow_move%0d", k), tk,
                  mk_exp(320 + 10 * k, 240, 310 + 10 * k, 240, (k < 16) ? k : 16, 1, 0, 0));
            apply($sformatf("grow_ate%0d", k), mk_in(0, 0, 0, 0, 0, 1),
                  mk_exp(320 + 10 * k, 240, 310 + 10 * k, 240, (k < 16) ? k : 16, 1, 0, 1));
        end
        apply("grow_sat", tk, mk_exp(500, 240, 490, 240, 16, 1, 0, 0));

        // Asynchronous reset asserted in the middle of the CHECK cycle.
        #2;
        sb.push_back(mk_exp(320, 240, 0, 0, 1, 0, 0, 0));
        rst = 1'b1;
        #1;
        check_pop("async_rst_mid_check");
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("start_after_rst", mk_in(1, 0, 0, 0, 0, 0), mk_exp(320, 240, 0, 0, 1, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
